stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/lap/clear controller for the stopwatch datapath (tick divider, ms/s/min counters, 7-seg).
//  Converts three raw push-buttons into clean command pulses, then sequences the counters
//  through a 4-state FSM. Produces count-enable, clear and display-hold controls plus a lap tally.
//  Sits between board buttons and the counter/display chain; replaces direct gating of tick by a level.
// PARAMETERS
//  DEB_CYCLES  50000  consecutive stable clk cycles required to accept a button level change (>=2)
//  DEB_W       16     width of debounce counter; must satisfy 2**DEB_W > DEB_CYCLES
//  LAP_MAX     15     saturation value of lap_cnt (fits in 4 bits)
// PORTS
//  clk         in   1  system clock, single domain
//  rst         in   1  synchronous, active-high reset
//  start_stop  in   1  raw button, async to clk, active-high: toggle run/stop
//  lap_btn     in   1  raw button, async, active-high: freeze/release display while running
//  clr_btn     in   1  raw button, async, active-high: zero counters (stopped states only)
//  run_en      out  1  registered; ANDed with tick to advance counters
//  cnt_clr     out  1  registered 1-cycle pulse; synchronous clear for all counters
//  disp_hold   out  1  registered; display latches hold last value while high
//  lap_strobe  out  1  registered 1-cycle pulse; display latches capture counter value
//  lap_cnt     out  4  registered lap tally, saturating at LAP_MAX
//  state       out  2  current FSM state (debug/LED): 0 IDLE, 1 RUN, 2 LAP, 3 STOP
// BEHAVIOUR
//  Reset: state=IDLE; run_en, cnt_clr, disp_hold, lap_strobe = 0; lap_cnt = 0; sync FFs and
//   debounce counters = 0; debounced levels = 0. Reset mid-press: press is lost, button must be released (debounced low) and pressed again.
//  Input path per button: 2-FF synchronizer -> debouncer (counter reloads to 0 whenever sync level
//   == debounced level; debounced level flips when count reaches DEB_CYCLES-1) -> rising-edge
//   detect -> 1-cycle press pulse. Release edges produce nothing. Held button = one pulse only.
//  Press pulses: p_ss, p_lap, p_clr. Priority in the same cycle: p_clr > p_ss > p_lap; at most one
//   command acted on per cycle, lower-priority pulses that cycle are dropped (not queued).
//  FSM (transitions on the clk edge where the pulse is high; outputs registered with the new state):
//   IDLE: p_ss -> RUN; p_clr -> IDLE + cnt_clr pulse; p_lap ignored.
//   RUN : p_ss -> STOP; p_lap -> LAP (lap_strobe pulse, lap_cnt+1); p_clr ignored.
//   LAP : p_lap -> RUN (disp_hold released); p_ss -> STOP (disp_hold released); p_clr ignored.
//   STOP: p_ss -> RUN; p_clr -> IDLE + cnt_clr pulse, lap_cnt<=0; p_lap ignored.
//  Outputs: run_en=1 in RUN and LAP; disp_hold=1 only in LAP; cnt_clr/lap_strobe high exactly 1 cycle.
//  Latency: button level stable -> state change = 2 (sync) + DEB_CYCLES + 1 (edge) cycles;
//   state change and output update occur on the same edge.
//  lap_cnt: increments on each RUN->LAP; saturates at LAP_MAX (no wrap); cleared only by rst or clear in STOP.
//  Clear from IDLE with lap_cnt already 0: cnt_clr still pulses (idempotent).
//  No combinational path from any input to any output.
// STRUCTURE
//  Shared header (stopwatch_pkg.vh): state encodings ST_IDLE/ST_RUN/ST_LAP/ST_STOP, 2-bit state width.
//  Sub-module btn_debounce (params DEB_CYCLES, DEB_W; ports clk, rst, btn_raw, btn_press):
//   synchronizer + debouncer + edge detect; instantiated three times. FSM/lap tally in top body.
// TESTING (bench uses DEB_CYCLES=4, DEB_W=3)
//  1 Reset: assert rst 3 cycles with buttons high -> all outputs 0, state=0; no pulse until release+re-press.
//  2 Bounce: start_stop toggles every 2 cycles for 12 cycles then holds 1 -> exactly one transition to
//    RUN, 7 cycles after hold begins; run_en=1; no transition on release.
//  3 Lap: in RUN press lap -> lap_strobe 1 cycle, disp_hold=1, lap_cnt=1, run_en stays 1; press lap again
//    -> RUN, disp_hold=0; 17 further laps -> lap_cnt stops at 15.
//  4 Stop/clear: RUN->press start -> STOP, run_en=0; press clr -> cnt_clr 1 cycle, lap_cnt=0, state=IDLE;
//    press clr in RUN -> no cnt_clr, state unchanged.
//  5 Simultaneous: in STOP press clr and start on same cycle -> IDLE with cnt_clr, run_en stays 0;
//    in RUN press start and lap together -> STOP, no lap_strobe, lap_cnt unchanged.
//  6 Reset mid-LAP: rst while state=LAP -> next cycle state=IDLE, disp_hold=0, lap_cnt=0.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch run/lap/clear controller.
package stopwatch_ctrl_pkg;

  localparam int STATE_W = 2;
  localparam int LAP_W   = 4;
  localparam int N_BTN   = 3;

  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_CLR,
    CMD_SS,
    CMD_LAP
  } cmd_e;

  function automatic logic [LAP_W-1:0] lap_sat_inc(input logic [LAP_W-1:0] v,
                                                   input logic [LAP_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  logic                                 start_stop;
  logic                                 lap_btn;
  logic                                 clr_btn;
  logic                                 run_en;
  logic                                 cnt_clr;
  logic                                 disp_hold;
  logic                                 lap_strobe;
  logic [stopwatch_ctrl_pkg::LAP_W-1:0]   lap_cnt;
  logic [stopwatch_ctrl_pkg::STATE_W-1:0] state;

  modport master (
    output start_stop, lap_btn, clr_btn,
    input  run_en, cnt_clr, disp_hold, lap_strobe, lap_cnt, state
  );

  modport slave (
    input  start_stop, lap_btn, clr_btn,
    output run_en, cnt_clr, disp_hold, lap_strobe, lap_cnt, state
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Raw button -> 2-FF sync -> stability debouncer -> single press pulse on debounced rising edge.
module stopwatch_ctrl_btn_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_press
);
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d, deb_prev_q;
  logic             arm_q, arm_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] arm_cnt_q, arm_cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      deb_d = ~deb_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A button held through reset must be seen released for a full debounce
  // window before presses are accepted; the sync stages are included so the
  // reset-cleared flops cannot fake a released button.
  always_comb begin
    arm_d     = arm_q;
    arm_cnt_d = arm_cnt_q;
    if (!arm_q) begin
      if (sync1_q || sync2_q || deb_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == CNT_LAST) begin
        arm_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
      arm_q      <= 1'b0;
      arm_cnt_q  <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      arm_q      <= arm_d;
      arm_cnt_q  <= arm_cnt_d;
    end
  end

  assign btn_press = arm_q & deb_q & ~deb_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/lap/clear controller: debounced button commands sequence a 4-state FSM with registered outputs.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16,
  parameter int LAP_MAX    = 15
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  ctrl_if
);
  localparam logic [LAP_W-1:0] LAP_LIM = LAP_W'(LAP_MAX);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] press;
  cmd_e             cmd;

  state_e           state_q;
  logic             run_en_q, cnt_clr_q, disp_hold_q, lap_strobe_q;
  logic [LAP_W-1:0] lap_cnt_q;

  assign btn_raw[BTN_SS]  = ctrl_if.start_stop;
  assign btn_raw[BTN_LAP] = ctrl_if.lap_btn;
  assign btn_raw[BTN_CLR] = ctrl_if.clr_btn;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    stopwatch_ctrl_btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[gi]),
      .btn_press (press[gi])
    );
  end

  // Only the highest-priority pulse is considered; the others are dropped
  // even if that command is meaningless in the current state.
  always_comb begin
    cmd = CMD_NONE;
    if (press[BTN_CLR])      cmd = CMD_CLR;
    else if (press[BTN_SS])  cmd = CMD_SS;
    else if (press[BTN_LAP]) cmd = CMD_LAP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      run_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      disp_hold_q  <= 1'b0;
      lap_strobe_q <= 1'b0;
      lap_cnt_q    <= '0;
    end else begin
      cnt_clr_q    <= 1'b0;
      lap_strobe_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd == CMD_CLR) begin
            cnt_clr_q <= 1'b1;
          end else if (cmd == CMD_SS) begin
            state_q  <= ST_RUN;
            run_en_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cmd == CMD_SS) begin
            state_q  <= ST_STOP;
            run_en_q <= 1'b0;
          end else if (cmd == CMD_LAP) begin
            state_q      <= ST_LAP;
            disp_hold_q  <= 1'b1;
            lap_strobe_q <= 1'b1;
            lap_cnt_q    <= lap_sat_inc(lap_cnt_q, LAP_LIM);
          end
        end
        ST_LAP: begin
          if (cmd == CMD_SS) begin
            state_q     <= ST_STOP;
            run_en_q    <= 1'b0;
            disp_hold_q <= 1'b0;
          end else if (cmd == CMD_LAP) begin
            state_q     <= ST_RUN;
            disp_hold_q <= 1'b0;
          end
        end
        ST_STOP: begin
          if (cmd == CMD_CLR) begin
            state_q   <= ST_IDLE;
            cnt_clr_q <= 1'b1;
            lap_cnt_q <= '0;
          end else if (cmd == CMD_SS) begin
            state_q  <= ST_RUN;
            run_en_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ctrl_if.state      = state_q;
  assign ctrl_if.run_en     = run_en_q;
  assign ctrl_if.cnt_clr    = cnt_clr_q;
  assign ctrl_if.disp_hold  = disp_hold_q;
  assign ctrl_if.lap_strobe = lap_strobe_q;
  assign ctrl_if.lap_cnt    = lap_cnt_q;

endmodule
